// File: rtl/octal_scan_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : octal_scan_encoder_if
// Brief    : Vector-in / index-out handshake bundle for octal_scan_encoder.
//            The err signal exists only when OSE_ZERO_ERR_EN is defined.
// Revision : 1.0
// ============================================================================
interface octal_scan_encoder_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] i;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] y;
    logic       out_last;
`ifdef OSE_ZERO_ERR_EN
    logic       err;
`endif

    modport master (
        output in_valid, i, out_ready,
`ifdef OSE_ZERO_ERR_EN
        input  err,
`endif
        input  in_ready, out_valid, y, out_last
    );

    modport slave (
        input  in_valid, i, out_ready,
`ifdef OSE_ZERO_ERR_EN
        output err,
`endif
        output in_ready, out_valid, y, out_last
    );
endinterface
`default_nettype wire

// File: rtl/octal_scan_encoder.sv
`default_nettype none
// ============================================================================
// Module   : octal_scan_encoder
// Brief    : Streams the indices of all set bits of an 8-bit vector, lowest
//            first. Optional zero-vector error pulse: OSE_ZERO_ERR_EN.
// Revision : 1.0
// ============================================================================
module octal_scan_encoder (
    input  wire logic            clk,
    input  wire logic            rst,
    octal_scan_encoder_if.slave  bus
);
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t     r_state;
    logic [7:0] r_pending;
    logic       r_valid;
    logic [2:0] r_y;
    logic       r_last;
    logic       w_accept;
    logic       w_take;
    logic [7:0] w_rest;

    function automatic logic [2:0] f_low_idx(input logic [7:0] v);
        f_low_idx = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (v[k]) f_low_idx = k[2:0];
        end
    endfunction

    function automatic logic f_single(input logic [7:0] v);
        f_single = (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    assign w_accept = bus.in_valid && (r_state == IDLE);
    assign w_take   = r_valid && bus.out_ready;
    // Pending vector with its lowest set bit (the one being reported) removed.
    assign w_rest   = r_pending & (r_pending - 8'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pending <= 8'd0;
            r_valid   <= 1'b0;
            r_y       <= 3'd0;
            r_last    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept && (bus.i != 8'd0)) begin
                        r_state   <= EMIT;
                        r_pending <= bus.i;
                        r_valid   <= 1'b1;
                        r_y       <= f_low_idx(bus.i);
                        r_last    <= f_single(bus.i);
                    end
                end
                EMIT: begin
                    if (w_take) begin
                        if (r_last) begin
                            r_state   <= IDLE;
                            r_pending <= 8'd0;
                            r_valid   <= 1'b0;
                            r_y       <= 3'd0;
                            r_last    <= 1'b0;
                        end else begin
                            r_pending <= w_rest;
                            r_y       <= f_low_idx(w_rest);
                            r_last    <= f_single(w_rest);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef OSE_ZERO_ERR_EN
    logic r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept && (bus.i == 8'd0);
        end
    end

    assign bus.err = r_err;
`endif

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = r_valid;
    assign bus.y         = r_y;
    assign bus.out_last  = r_last;
endmodule
`default_nettype wire

// File: tb/tb_octal_scan_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_octal_scan_encoder
// Brief    : Directed self-checking bench for octal_scan_encoder.
// Revision : 1.0
// ============================================================================
module tb_octal_scan_encoder;
    logic clk;
    logic rst;
    int   vec_count;
    int   miscompares;

    octal_scan_encoder_if bus ();

    octal_scan_encoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vec_count++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_beat(input string tag, input logic [2:0] ey, input logic el);
        check({tag, ".valid"}, {7'd0, bus.out_valid}, 8'd1);
        check({tag, ".y"},     {5'd0, bus.y},         {5'd0, ey});
        check({tag, ".last"},  {7'd0, bus.out_last},  {7'd0, el});
    endtask

    task automatic expect_idle(input string tag);
        check({tag, ".valid"}, {7'd0, bus.out_valid}, 8'd0);
        check({tag, ".ready"}, {7'd0, bus.in_ready},  8'd1);
    endtask

    initial begin
        vec_count    = 0;
        miscompares  = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.i        = 8'd0;
        bus.out_ready = 1'b0;
        step();
        step();
        expect_idle("reset");
        check("reset.y",    {5'd0, bus.y},        8'd0);
        check("reset.last", {7'd0, bus.out_last}, 8'd0);
`ifdef OSE_ZERO_ERR_EN
        check("reset.err",  {7'd0, bus.err},      8'd0);
`endif
        rst = 1'b0;

        // 8'b0010_0100 with out_ready held high, accepted on first edge after reset
        bus.in_valid  = 1'b1;
        bus.i         = 8'h24;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check("v24.in_ready", {7'd0, bus.in_ready}, 8'd0);
        expect_beat("v24.b0", 3'd2, 1'b0);
        step();
        expect_beat("v24.b1", 3'd5, 1'b1);
        step();
        expect_idle("v24.end");

        // 8'hFF with a stall cycle before every handshake
        bus.in_valid = 1'b1;
        bus.i        = 8'hFF;
        step();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            expect_beat("vFF.beat", k[2:0], (k == 7));
            bus.out_ready = 1'b0;
            step();
            expect_beat("vFF.stall", k[2:0], (k == 7));
            bus.out_ready = 1'b1;
            step();
        end
        expect_idle("vFF.end");

        // One-hot vectors
        for (int k = 0; k < 8; k++) begin
            bus.in_valid = 1'b1;
            bus.i        = 8'd1 << k;
            step();
            bus.in_valid = 1'b0;
            expect_beat("onehot", k[2:0], 1'b1);
            step();
            expect_idle("onehot.end");
        end

        // Reset in the middle of 8'hF0
        bus.in_valid = 1'b1;
        bus.i        = 8'hF0;
        step();
        bus.in_valid = 1'b0;
        expect_beat("vF0.b0", 3'd4, 1'b0);
        step();
        expect_beat("vF0.b1", 3'd5, 1'b0);
        step();
        rst = 1'b1;
        #1;
        expect_idle("vF0.rst");
        check("vF0.rst.y", {5'd0, bus.y}, 8'd0);
        step();
        rst = 1'b0;
        expect_idle("vF0.post0");
        step();
        expect_idle("vF0.post1");
        bus.in_valid = 1'b1;
        bus.i        = 8'h01;
        step();
        bus.in_valid = 1'b0;
        expect_beat("v01.b0", 3'd0, 1'b1);
        step();
        expect_idle("v01.end");

        // Zero vector
        bus.in_valid = 1'b1;
        bus.i        = 8'h00;
        step();
        bus.in_valid = 1'b0;
        expect_idle("v00.a");
`ifdef OSE_ZERO_ERR_EN
        check("v00.err1", {7'd0, bus.err}, 8'd1);
`endif
        step();
        expect_idle("v00.b");
`ifdef OSE_ZERO_ERR_EN
        check("v00.err0", {7'd0, bus.err}, 8'd0);
`endif

        // Input changes during EMIT are ignored
        bus.in_valid = 1'b1;
        bus.i        = 8'h0C;
        step();
        bus.i = 8'h01;
        expect_beat("v0C.b0", 3'd2, 1'b0);
        step();
        expect_beat("v0C.b1", 3'd3, 1'b1);
        step();
        expect_idle("v0C.bubble");
        step();
        bus.in_valid = 1'b0;
        expect_beat("v0C.next", 3'd0, 1'b1);
        step();
        expect_idle("v0C.end");

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/octal_scan_encoder.md
OCTAL_SCAN_ENCODER -- requirements
Module: octal_scan_encoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 in_valid  input  1  producer offers vector i.
REQ-005 in_ready  output  1  block accepts a vector this cycle.
REQ-006 i  input  8  line vector; bit k set means line k active, any number of bits set.
REQ-007 out_valid  output  1  y holds a valid line index.
REQ-008 out_ready  input  1  consumer takes y this cycle.
REQ-009 y  output  3  binary index (0..7) of an active line.
REQ-010 out_last  output  1  y is the final index of the current vector.
REQ-011 err  output  1  zero-vector flag; present only with OSE_ZERO_ERR_EN.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE and EMIT.
REQ-013 in_ready SHALL be 1 exactly when the state is IDLE, decoded combinationally from state.
REQ-014 Accept: in_valid and in_ready at a rising edge, with i nonzero, SHALL latch i into an internal 8-bit pending register and enter EMIT.
REQ-015 Accept with i == 0 SHALL keep the FSM in IDLE, with no output beat.
REQ-016 In EMIT, out_valid SHALL be 1, y SHALL equal the index of the lowest set pending bit, and out_last SHALL be 1 iff exactly one pending bit remains.
REQ-017 Latency: the first beat SHALL appear with out_valid=1 in the cycle after the accept edge.
REQ-018 Output handshake: out_valid and out_ready at an edge SHALL clear the reported pending bit, and the next beat SHALL follow in the next cycle.
REQ-019 Indices SHALL be emitted in strictly ascending order, one per handshake, with no duplicates or omissions.
REQ-020 Backpressure: while out_valid=1 and out_ready=0, y, out_last and pending SHALL hold stable.
REQ-021 A handshake with out_last=1 SHALL return the FSM to IDLE.
REQ-022 After that final handshake, out_valid SHALL be 0 and in_ready SHALL be 1 in the next cycle, a one-cycle bubble between vectors.
REQ-023 Changes on i and in_valid while in EMIT SHALL be ignored.
REQ-024 Vector 8'hFF SHALL produce 8 beats, y = 0..7, with out_last on y = 7.
REQ-025 Vector 8'h80 SHALL produce a single beat, y = 7, out_last = 1.
REQ-026 out_valid, y and out_last SHALL be driven from registers, with no combinational path from out_ready.

Reset
REQ-027 Asserting rst at any time SHALL immediately force IDLE, pending = 0, out_valid = 0, y = 0, out_last = 0, err = 0 and in_ready = 1.
REQ-028 Reset mid-vector SHALL discard all remaining indices; no beat SHALL appear after reset deasserts until a new accept.
REQ-029 The first accept SHALL be possible at the first rising edge after rst deasserts.

Configuration
REQ-030 Macro OSE_ZERO_ERR_EN SHALL gate zero-vector error reporting.
REQ-031 With OSE_ZERO_ERR_EN defined, accepting i == 0 SHALL pulse err = 1 for exactly one cycle, the cycle after the accept edge.
REQ-032 With OSE_ZERO_ERR_EN defined, err SHALL be 0 in all other cycles.
REQ-033 With OSE_ZERO_ERR_EN undefined, the err port and its logic SHALL be absent, and zero vectors SHALL be silently consumed.

Verification
REQ-034 Apply i = 8'b0010_0100 with out_ready held at 1 -> beats y = 2 (last = 0), then y = 5 (last = 1); in_ready = 1 one cycle later.
REQ-035 Apply i = 8'hFF with out_ready toggling 1,0,1,0 -> y = 0..7 in order, each y stable during stall cycles, last only on y = 7.
REQ-036 Apply all 8 one-hot vectors 8'h01..8'h80 -> exactly one beat each, y = 0..7, last = 1 every beat.
REQ-037 Assert rst after the second beat of 8'hF0 -> out_valid falls immediately, with no further beats; then 8'h01 -> single beat y = 0.
REQ-038 Apply i = 0 with in_valid = 1 -> no out_valid and in_ready stays 1; with OSE_ZERO_ERR_EN, a single-cycle err pulse.
REQ-039 Change i to 8'h01 with in_valid = 1 while 8'h0C is emitting -> only y = 2, 3 are emitted; 8'h01 is accepted after IDLE is reached.
